twos_complement_serial: RTL and testbench

//   Parametrised multi-cycle two's-complement unit: pass, negate or absolute value of a WIDTH-bit

---
 rtl/twos_pkg.sv | 18 +
 rtl/twos_digit_cell.sv | 18 +
 rtl/twos_complement_serial.sv | 123 ++++++++++++
 tb/tb_twos_complement_serial.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/twos_pkg.sv
// Shared encodings and helpers for the serial two's-complement unit.
package twos_pkg;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_NEG  = 2'b01;
  localparam logic [1:0] MODE_ABS  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic int unsigned num_digits(input int unsigned width, input int unsigned digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/twos_digit_cell.sv
// One DIGIT-bit slice of the complement chain: optional invert, then add the incoming carry.
module twos_digit_cell #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic             inv,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
);

  logic [DIGIT:0] sum;

  assign sum  = {1'b0, a ^ {DIGIT{inv}}} + {{DIGIT{1'b0}}, cin};
  assign s    = sum[DIGIT-1:0];
  assign cout = sum[DIGIT];

endmodule

// File: rtl/twos_complement_serial.sv
// Digit-serial pass / negate / absolute value unit with valid/ready on both sides.
module twos_complement_serial
  import twos_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int unsigned   N       = num_digits(WIDTH, DIGIT);
  localparam int unsigned   CW      = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(N - 1);

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : gen_param_check
    $error("twos_complement_serial: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_e               state_q, state_d;
  logic                 accept;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     op_q;
  logic [WIDTH-1:0]     res_q;
  logic                 carry_q;
  logic                 inv_q;
  logic                 msb_q;
  logic [WIDTH-1:0]     out_data_q;
  logic                 out_ovf_q;
  logic                 out_zero_q;
  logic                 inv_in;
  logic [DIGIT-1:0]     digit_s;
  logic                 digit_cout;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]     res_shift;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == LastCnt) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = accept ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = ~rst & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready));
    out_valid = (state_q == ST_DONE);
    accept    = in_valid & in_ready;
  end

  assign inv_in = (in_mode == MODE_NEG) | ((in_mode == MODE_ABS) & in_data[WIDTH-1]);

  twos_digit_cell #(
    .DIGIT(DIGIT)
  ) u_cell (
    .a   (op_q[DIGIT-1:0]),
    .inv (inv_q),
    .cin (carry_q),
    .s   (digit_s),
    .cout(digit_cout)
  );

  // New digit enters at the MSB end; after N steps the first digit sits at the LSB.
  assign res_cat   = {digit_s, res_q};
  assign res_shift = res_cat[WIDTH+DIGIT-1:DIGIT];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      op_q       <= '0;
      res_q      <= '0;
      carry_q    <= 1'b0;
      inv_q      <= 1'b0;
      msb_q      <= 1'b0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
      out_zero_q <= 1'b0;
    end else if (accept) begin
      cnt_q   <= '0;
      op_q    <= in_data;
      msb_q   <= in_data[WIDTH-1];
      inv_q   <= inv_in;
      carry_q <= inv_in;
    end else if (state_q == ST_RUN) begin
      cnt_q   <= cnt_q + CW'(1);
      op_q    <= op_q >> DIGIT;
      res_q   <= res_shift;
      carry_q <= digit_cout;
      if (cnt_q == LastCnt) begin
        out_data_q <= res_shift;
        out_ovf_q  <= inv_q & msb_q & res_shift[WIDTH-1];
        out_zero_q <= ~|res_shift;
      end
    end
  end

  assign out_data = out_data_q;
  assign out_ovf  = out_ovf_q;
  assign out_zero = out_zero_q;

endmodule

// File: tb/tb_twos_complement_serial.sv
// Scoreboard bench: directed WIDTH=16/DIGIT=4 tests plus randomised alternate configurations.
module tb_twos_complement_serial;
  import twos_pkg::*;

  localparam int unsigned NMain = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [1:0]  in_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_ovf;
  logic        out_zero;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [65:0] sb_q[$];
  int          acc_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  twos_complement_serial #(
    .WIDTH(16),
    .DIGIT(4)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ovf  (out_ovf),
    .out_zero (out_zero)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns {zero, ovf, data} for -x / |x| / x modulo 2^w.
  function automatic logic [65:0] ref_model(input int unsigned w, input logic [63:0] x,
                                            input logic [1:0] m);
    logic [63:0] mask, minv, xm, r;
    logic        neg, ovf;
    mask = (64'd1 << w) - 64'd1;
    minv = 64'd1 << (w - 1);
    xm   = x & mask;
    neg  = (m == 2'b01) || ((m == 2'b10) && ((xm & minv) != 0));
    r    = neg ? ((64'd0 - xm) & mask) : xm;
    ovf  = neg && (xm == minv);
    return {(r == 64'd0), ovf, r};
  endfunction

  task automatic send(input logic [15:0] d, input logic [1:0] m);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("accept", in_ready, 1);
    sb_q.push_back(ref_model(16, 64'(d), m));
    acc_q.push_back(cyc + 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  logic        prev_valid = 1'b0;
  int          mon_a;
  logic [65:0] mon_e;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (acc_q.size() == 0) check_eq("lat_orphan", acc_q.size(), 1);
        else begin
          mon_a = acc_q.pop_front();
          check_eq("latency", cyc - mon_a, NMain);
        end
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) check_eq("sb_orphan", sb_q.size(), 1);
        else begin
          mon_e = sb_q.pop_front();
          check_eq("data", out_data, mon_e[63:0]);
          check_eq("ovf", out_ovf, mon_e[64]);
          check_eq("zero", out_zero, mon_e[65]);
        end
      end
      prev_valid = out_valid;
    end
  end

  // Alternate configurations: (16,1), (16,16), (4,2).
  for (genvar g = 0; g < 3; g++) begin : gen_cfg
    localparam int unsigned W = (g == 2) ? 4 : 16;
    localparam int unsigned D = (g == 0) ? 1 : ((g == 1) ? 16 : 2);
    localparam int unsigned N = W / D;

    logic         c_rst = 1'b1;
    logic         c_iv = 1'b0;
    logic         c_ir;
    logic [W-1:0] c_id = '0;
    logic [1:0]   c_im = '0;
    logic         c_ov;
    logic         c_or = 1'b1;
    logic [W-1:0] c_od;
    logic         c_ovf;
    logic         c_zr;
    bit           done = 1'b0;
    logic [65:0]  exp_q[$];

    twos_complement_serial #(
      .WIDTH(W),
      .DIGIT(D)
    ) u_dut (
      .clk      (clk),
      .rst      (c_rst),
      .in_valid (c_iv),
      .in_ready (c_ir),
      .in_data  (c_id),
      .in_mode  (c_im),
      .out_valid(c_ov),
      .out_ready(c_or),
      .out_data (c_od),
      .out_ovf  (c_ovf),
      .out_zero (c_zr)
    );

    initial begin
      logic [W-1:0] x;
      logic [1:0]   m;
      logic [65:0]  e;
      int           n;
      repeat (3) @(posedge clk);
      #1 c_rst = 1'b0;
      for (int k = 0; k < 24; k++) begin
        if (k % 3 == 0) begin
          case ((k / 3) % 4)
            0:       x = '0;
            1:       begin x = '0; x[W-1] = 1'b1; end
            2:       x = '1;
            default: x = W'(1);
          endcase
        end else begin
          x = W'($urandom);
        end
        m = (k < 12) ? ((k % 2 == 1) ? MODE_NEG : MODE_ABS) : 2'($urandom_range(0, 3));
        c_iv = 1'b1;
        c_id = x;
        c_im = m;
        @(negedge clk);
        check_eq($sformatf("cfg%0d_rdy", g), c_ir, 1);
        exp_q.push_back(ref_model(W, 64'(x), m));
        @(posedge clk);
        #1 c_iv = 1'b0;
        n = 0;
        do begin
          @(posedge clk);
          n++;
          @(negedge clk);
        end while (!c_ov && n < 40);
        check_eq($sformatf("cfg%0d_lat", g), n, N);
        e = exp_q.pop_front();
        check_eq($sformatf("cfg%0d_data", g), 64'(c_od), e[63:0]);
        check_eq($sformatf("cfg%0d_ovf", g), c_ovf, e[64]);
        check_eq($sformatf("cfg%0d_zero", g), c_zr, e[65]);
        @(posedge clk);
        #1;
      end
      done = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [65:0] e;
    int          n;

    // Reset state
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst_ready", in_ready, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_data", out_data, 0);
    check_eq("rst_ovf", out_ovf, 0);
    check_eq("rst_zero", out_zero, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("idle_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Negate corner cases, issued back to back
    send(16'h0001, MODE_NEG);
    drain();
    send(16'h8000, MODE_NEG);
    send(16'h0000, MODE_NEG);
    send(16'hFFFF, MODE_NEG);
    drain();

    // Absolute value and reserved mode
    send(16'hFFF6, MODE_ABS);
    send(16'h0005, MODE_ABS);
    send(16'h8000, MODE_ABS);
    send(16'h1234, 2'b11);
    drain();

    // Backpressure in DONE, then simultaneous drain + accept
    out_ready = 1'b0;
    e = ref_model(16, 64'h8000, MODE_ABS);
    send(16'h8000, MODE_ABS);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_valid", out_valid, 1);
      check_eq("bp_data", out_data, e[63:0]);
      check_eq("bp_ovf", out_ovf, e[64]);
      check_eq("bp_zero", out_zero, e[65]);
      check_eq("bp_ready", in_ready, 0);
      if (i < 2) @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(16'h00FF, MODE_NEG);
    drain();

    // Reset during RUN discards the operation
    send(16'h1234, MODE_NEG);
    in_valid = 1'b1;
    in_data  = 16'hABCD;
    in_mode  = MODE_NEG;
    @(negedge clk);
    check_eq("run_ready", in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    in_valid = 1'b0;
    sb_q.delete();
    acc_q.delete();
    @(posedge clk);
    @(negedge clk);
    check_eq("mid_rst_valid", out_valid, 0);
    check_eq("mid_rst_data", out_data, 0);
    check_eq("mid_rst_ovf", out_ovf, 0);
    check_eq("mid_rst_zero", out_zero, 0);
    check_eq("mid_rst_ready", in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", in_ready, 1);
    check_eq("post_rst_valid", out_valid, 0);
    @(posedge clk);
    #1;
    send(16'h0003, MODE_NEG);
    drain();

    n = 0;
    while (!(gen_cfg[0].done && gen_cfg[1].done && gen_cfg[2].done) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check_eq("cfg_done", {gen_cfg[0].done, gen_cfg[1].done, gen_cfg[2].done}, 3'b111);
    check_eq("sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
